rr_moore_arbiter: RTL and testbench

- Round-robin arbiter that shares one single-ported resource (e.g. the unified memory port used by fetch and load/store) among NREQ requesters.
- Built as a Moore FSM: grant outputs depend only on registered state (state + owner), never directly on req or done.
- Enforces a maximum tenure per grant and one dead turnaround cycle between owners.

---
 rtl/rr_moore_arbiter.sv | 124 ++++++++++++
 tb/tb_rr_moore_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_moore_arbiter.sv
// Round-robin Moore arbiter with a capped tenure and a one-cycle GAP between owners.
// Optional macro ARB_LOCK_EN adds a lock input that suspends the tenure cap while granted.
module rr_moore_arbiter #(
    parameter int NREQ     = 4,
    parameter int MAX_HOLD = 8,
    parameter int IDW      = $clog2(NREQ),
    parameter int CW       = $clog2(MAX_HOLD) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            done,
`ifdef ARB_LOCK_EN
    input  logic            lock,
`endif
    output logic [NREQ-1:0] gnt,
    output logic            gnt_valid,
    output logic [IDW-1:0]  gnt_id,
    output logic            busy,
    output logic            timeout
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [IDW-1:0] last_ptr_q, last_ptr_d;
    logic [CW-1:0]  hold_cnt_q, hold_cnt_d;
    logic           timeout_q, timeout_d;
    logic [IDW-1:0] winner;
    logic [IDW:0]   scan_idx;
    logic           any_req;
    logic           normal_exit;
    logic           at_limit;
    logic           lock_active;

`ifdef ARB_LOCK_EN
    assign lock_active = lock;
`else
    assign lock_active = 1'b0;
`endif

    // Scan from the farthest offset down so the nearest requester after last_ptr wins.
    always_comb begin
        winner   = last_ptr_q;
        scan_idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            scan_idx = {1'b0, last_ptr_q} + (IDW+1)'(k);
            if (scan_idx >= (IDW+1)'(NREQ)) begin
                scan_idx = scan_idx - (IDW+1)'(NREQ);
            end
            if (req[scan_idx[IDW-1:0]]) begin
                winner = scan_idx[IDW-1:0];
            end
        end
    end

    assign any_req     = |req;
    assign normal_exit = done || !req[owner_q];
    assign at_limit    = (hold_cnt_q == CW'(MAX_HOLD - 1)) && !lock_active;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_ptr_d = last_ptr_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
        case (state_q)
            IDLE, GAP: begin
                if (any_req) begin
                    state_d    = GRANT;
                    owner_d    = winner;
                    hold_cnt_d = '0;
                end else begin
                    state_d    = IDLE;
                end
            end
            GRANT: begin
                // A normal exit in the same cycle as the cap takes precedence: no timeout.
                if (normal_exit || at_limit) begin
                    state_d    = GAP;
                    last_ptr_d = owner_q;
                    timeout_d  = !normal_exit;
                end else if (!lock_active) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            last_ptr_q <= IDW'(NREQ - 1);
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_ptr_q <= last_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        gnt = '0;
        if (state_q == GRANT) begin
            gnt[owner_q] = 1'b1;
        end
    end

    assign gnt_valid = |gnt;
    assign gnt_id    = gnt_valid ? owner_q : '0;
    assign busy      = (state_q == GRANT) || (state_q == GAP);
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_moore_arbiter.sv
// Self-checking bench for rr_moore_arbiter: vector tables feed a scoreboard queue that is
// popped one cycle later when the registered outputs are sampled.
module tb_rr_moore_arbiter;

    typedef struct packed {
        logic [3:0] req;
        logic       done;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       busy;
        logic       tmo;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       done = 1'b0;
`ifdef ARB_LOCK_EN
    logic       lock = 1'b0;
`endif
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];
    vec_t exp_q[$];

    rr_moore_arbiter #(.NREQ(4), .MAX_HOLD(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
`ifdef ARB_LOCK_EN
        .lock      (lock),
`endif
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .busy      (busy),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [3:0] r, input logic d, input logic [3:0] g,
                                input logic [1:0] id, input logic b, input logic t);
        vec_t v;
        v.req  = r;
        v.done = d;
        v.gnt  = g;
        v.id   = id;
        v.busy = b;
        v.tmo  = t;
        return v;
    endfunction

    function automatic void add_vec(input logic [3:0] r, input logic d, input logic [3:0] g,
                                    input logic [1:0] id, input logic b, input logic t);
        vecs.push_back(mk(r, d, g, id, b, t));
    endfunction

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name);
        vec_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: scoreboard empty, got gnt %0h, expected an entry", name, gnt);
            return;
        end
        e = exp_q.pop_front();
        checkField({name, " gnt"},       32'(gnt),       32'(e.gnt));
        checkField({name, " gnt_valid"}, 32'(gnt_valid), 32'(|e.gnt));
        checkField({name, " busy"},      32'(busy),      32'(e.busy));
        checkField({name, " timeout"},   32'(timeout),   32'(e.tmo));
        if (|e.gnt) begin
            checkField({name, " gnt_id"}, 32'(gnt_id), 32'(e.id));
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
    task automatic applyStimulus(input vec_t v, input string name);
        @(negedge clk);
        req  = v.req;
        done = v.done;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        checkOutput(name);
    endtask

    task automatic runTable(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], $sformatf("%s[%0d]", tag, i));
        end
        vecs.delete();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected to finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(mk(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0));
        checkOutput("por");
        checkField("por gnt_id", 32'(gnt_id), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        add_vec(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        add_vec(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        add_vec(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        add_vec(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        add_vec(4'b0001, 1'b1, 4'b0000, 2'd0, 1'b1, 1'b0);
        add_vec(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        runTable("single");

        // Owner 0 was last, so 1 wins; then reset asynchronously in the middle of the grant.
        add_vec(4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
        runTable("pre_reset");
        #2;
        rst = 1'b0;
        #1;
        exp_q.push_back(mk(4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0));
        checkOutput("async_reset");
        checkField("async_reset gnt_id", 32'(gnt_id), 32'd0);
        @(posedge clk);
        #1;
        exp_q.push_back(mk(4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0));
        checkOutput("reset_hold");
        rst = 1'b1;

        for (int i = 0; i < 5; i++) begin
            add_vec(4'b1111, 1'b0, 4'b0001 << (i % 4), 2'(i % 4), 1'b1, 1'b0);
            add_vec(4'b1111, 1'b1, 4'b0000, 2'd0, 1'b1, 1'b0);
        end
        add_vec(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        runTable("round_robin");

        for (int i = 0; i < 8; i++) begin
            add_vec(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
        end
        add_vec(4'b0100, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b1);
        add_vec(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
        add_vec(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b0);
        add_vec(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        runTable("timeout");

        add_vec(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
        add_vec(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
        add_vec(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b0);
        add_vec(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        runTable("withdraw");

        for (int i = 0; i < 8; i++) begin
            add_vec(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
        end
        add_vec(4'b0010, 1'b1, 4'b0000, 2'd0, 1'b1, 1'b0);
        add_vec(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        runTable("done_at_limit");

        // Last owner is 1: 3 beats 0, a late request from 1 waits its turn.
        add_vec(4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
        add_vec(4'b1011, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
        add_vec(4'b1011, 1'b1, 4'b0000, 2'd0, 1'b1, 1'b0);
        add_vec(4'b1011, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        add_vec(4'b0010, 1'b1, 4'b0000, 2'd0, 1'b1, 1'b0);
        add_vec(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
        add_vec(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b1, 1'b0);
        add_vec(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        runTable("skip");

`ifdef ARB_LOCK_EN
        lock = 1'b1;
        for (int i = 0; i < 22; i++) begin
            add_vec(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
        end
        runTable("lock_hold");
        lock = 1'b0;
        add_vec(4'b0100, 1'b1, 4'b0000, 2'd0, 1'b1, 1'b0);
        add_vec(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        runTable("lock_release");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
